// File: rtl/bit_serial_alu_pkg.sv
// Shared types and op-code constants for the bit-serial ALU.
package bit_serial_alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam logic [1:0] OP_NOR = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   // ADD and SUB share op[1]; only those produce a meaningful carry.
   function automatic logic is_arith(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/bit_serial_alu_alu1bit.sv
// Combinational one-bit datapath slice: NOR, XOR, full-add, full-subtract.
module alu1bit
   import bit_serial_alu_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_cin,
   input  logic [1:0] i_op,
   output logic       o_s,
   output logic       o_cout
);

   logic w_b;

   always_comb begin
      // SUB is a + ~b + 1; the +1 comes from the seeded carry register.
      w_b    = (i_op == OP_SUB) ? ~i_b : i_b;
      o_s    = 1'b0;
      o_cout = 1'b0;
      unique case (i_op)
         OP_NOR: o_s = ~(i_a | i_b);
         OP_XOR: o_s = i_a ^ i_b;
         OP_ADD, OP_SUB: begin
            o_s    = i_a ^ w_b ^ i_cin;
            o_cout = (i_a & w_b) | (i_cin & (i_a ^ w_b));
         end
         default: o_s = 1'b0;
      endcase
   end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU, LSB first, one bit per cycle. Define BIT_SERIAL_ALU_OVF_EN to add the
// signed-overflow output ovf.
module bit_serial_alu
   import bit_serial_alu_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   op_in,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         carry_out
`ifdef BIT_SERIAL_ALU_OVF_EN
   ,output logic        ovf
`endif
);

   localparam int unsigned CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_e        r_state;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic [1:0]    r_op;
   logic          r_carry;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_result;
   logic          r_cout;
   logic          r_busy;
   logic          r_done;
   logic          r_ovf;

   logic w_s;
   logic w_cout;

   alu1bit u_alu1bit (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .i_op   (r_op),
      .o_s    (w_s),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_NOR;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a      <= a_in;
                  r_b      <= b_in;
                  r_op     <= op_in;
                  r_carry  <= (op_in == OP_SUB);
                  r_cnt    <= '0;
                  r_result <= '0;
                  r_cout   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               r_a      <= r_a >> 1;
               r_b      <= r_b >> 1;
               r_result <= {w_s, r_result[N-1:1]};
               r_carry  <= w_cout;
               if (r_cnt == CNT_LAST) begin
                  // r_carry here is the carry into the MSB.
                  r_cout  <= is_arith(r_op) & w_cout;
                  r_ovf   <= is_arith(r_op) & (r_carry ^ w_cout);
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign carry_out = r_cout;
`ifdef BIT_SERIAL_ALU_OVF_EN
   assign ovf       = r_ovf;
`else
   logic w_unused_ovf;
   assign w_unused_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu (N=8); define BIT_SERIAL_ALU_OVF_EN to also check ovf.
module tb_bit_serial_alu;

   localparam int unsigned N = 8;

   typedef struct packed {
      logic [N-1:0] res;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [1:0]   op_in;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         carry_out;
`ifdef BIT_SERIAL_ALU_OVF_EN
   logic         ovf;
`endif

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   last_edges;

   bit_serial_alu #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op_in     (op_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out)
`ifdef BIT_SERIAL_ALU_OVF_EN
      ,.ovf      (ovf)
`endif
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [N-1:0] a,
                                  input logic [N-1:0] b);
      exp_t     e;
      logic [N:0] wide;
      e = '0;
      case (op)
         2'b00: e.res = ~(a | b);
         2'b01: e.res = a ^ b;
         2'b10: begin
            wide   = {1'b0, a} + {1'b0, b};
            e.res  = wide[N-1:0];
            e.cout = wide[N];
            e.ovf  = (a[N-1] == b[N-1]) && (e.res[N-1] != a[N-1]);
         end
         default: begin
            e.res  = a - b;
            e.cout = (a >= b);
            e.ovf  = (a[N-1] != b[N-1]) && (e.res[N-1] != a[N-1]);
         end
      endcase
      return e;
   endfunction

   task automatic compare(input string tag, input exp_t e);
      check_eq({tag, ".result"}, 32'(result), 32'(e.res));
      check_eq({tag, ".carry_out"}, 32'(carry_out), 32'(e.cout));
`ifdef BIT_SERIAL_ALU_OVF_EN
      check_eq({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
`endif
   endtask

   // Waits for done (bounded), pops the scoreboard and checks the one-cycle pulse.
   task automatic collect(input string tag);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 50) begin
         @(posedge clk);
         #1;
         k++;
      end
      last_edges = k;
      if (done !== 1'b1) begin
         check_eq({tag, ".timeout"}, 32'(done), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
         return;
      end
      compare(tag, sb.pop_front());
      @(posedge clk);
      #1;
      check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic do_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input string tag);
      @(negedge clk);
      op_in = op;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back(model(op, a, b));
      check_eq({tag, ".busy"}, 32'(busy), 32'd1);
      collect(tag);
      // Edges counted inclusive of the accepting edge.
      check_eq({tag, ".latency"}, 32'(last_edges + 1), 32'(N + 1));
   endtask

   initial begin
      int  t[2];
      int  nd;
      int  cyc;
      bit  saw_done;

      rst_n = 1'b0;
      start = 1'b0;
      op_in = 2'b00;
      a_in  = '0;
      b_in  = '0;
      #50;
      check_eq("reset.busy", 32'(busy), 32'd0);
      check_eq("reset.done", 32'(done), 32'd0);
      check_eq("reset.result", 32'(result), 32'd0);
      check_eq("reset.carry_out", 32'(carry_out), 32'd0);
`ifdef BIT_SERIAL_ALU_OVF_EN
      check_eq("reset.ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      do_op(2'b10, 8'h0F, 8'h01, "add_0f_01");
      do_op(2'b10, 8'hFF, 8'h01, "add_ff_01");
      do_op(2'b10, 8'h7F, 8'h01, "add_7f_01");
      do_op(2'b11, 8'h05, 8'h03, "sub_05_03");
      do_op(2'b11, 8'h03, 8'h05, "sub_03_05");
      do_op(2'b11, 8'h80, 8'h01, "sub_80_01");
      do_op(2'b00, 8'hF0, 8'h0C, "nor_f0_0c");
      do_op(2'b01, 8'hAA, 8'hFF, "xor_aa_ff");
      for (int i = 0; i < 8; i++) begin
         do_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), $sformatf("rand%0d", i));
      end

      // start and operand changes during RUN must not disturb the in-flight operation.
      @(negedge clk);
      op_in = 2'b10;
      a_in  = 8'h12;
      b_in  = 8'h34;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      sb.push_back(model(2'b10, 8'h12, 8'h34));
      repeat (2) @(negedge clk);
      op_in = 2'b11;
      a_in  = 8'h55;
      b_in  = 8'h66;
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      collect("start_in_run");
      check_eq("start_in_run.idle_busy", 32'(busy), 32'd0);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      op_in = 2'b10;
      a_in  = 8'h3C;
      b_in  = 8'h5A;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #5;
      rst_n = 1'b0;
      #1;
      check_eq("abort.busy", 32'(busy), 32'd0);
      check_eq("abort.done", 32'(done), 32'd0);
      check_eq("abort.result", 32'(result), 32'd0);
      check_eq("abort.carry_out", 32'(carry_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check_eq("abort.no_done", 32'(saw_done), 32'd0);
      do_op(2'b10, 8'h3C, 8'h5A, "after_abort");

      // start held high: back-to-back operations every N+2 cycles.
      @(negedge clk);
      op_in = 2'b11;
      a_in  = 8'h11;
      b_in  = 8'h22;
      start = 1'b1;
      sb.push_back(model(2'b11, 8'h11, 8'h22));
      sb.push_back(model(2'b11, 8'h11, 8'h22));
      nd  = 0;
      cyc = 0;
      while (nd < 2 && cyc < 60) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done === 1'b1) begin
            t[nd] = cyc;
            nd++;
            compare($sformatf("b2b%0d", nd), sb.pop_front());
            if (nd == 2) start = 1'b0;
         end
      end
      start = 1'b0;
      check_eq("b2b.count", 32'(nd), 32'd2);
      if (nd == 2) check_eq("b2b.period", 32'(t[1] - t[0]), 32'(N + 2));
      check_eq("sb.empty_at_end", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
